// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared defaults and state encodings for the argmax unit
//
// Purpose: single home for the parameter defaults and the FSM state types
// used by mnist_argmax_unit and argmax_cmp_stage.
// Ports: none (package).
package mnist_pkg;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int IDX_WIDTH_DEF   = 4;

  // Beat state: IDLE means the beat counter is at 0, ACCUM means a frame is
  // partially received.
  typedef enum logic {
    BEAT_IDLE  = 1'b0,
    BEAT_ACCUM = 1'b1
  } beat_state_e;

  // Output buffer state, tracked independently of the beat state.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/argmax_cmp_stage.sv
// rtl/argmax_cmp_stage.sv - combinational signed compare/update for one logit beat
//
// Purpose: folds one incoming logit into the running max / index (and the
// runner-up when ARGMAX_MARGIN_EN is defined). Purely combinational; the
// registers live in the top module.
// Ports:
//   first_i   - current beat is beat 0 (unconditional load)
//   beat_i    - index of the current beat
//   logit_i   - incoming signed logit
//   max_i     - running max before this beat
//   idx_i     - running max index before this beat
//   second_i  - running runner-up before this beat (ARGMAX_MARGIN_EN only)
//   max_o     - running max after this beat
//   idx_o     - running max index after this beat
//   second_o  - runner-up after this beat (ARGMAX_MARGIN_EN only)
// Configuration macro: ARGMAX_MARGIN_EN
module argmax_cmp_stage
  import mnist_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH  = IDX_WIDTH_DEF
) (
  input  logic                  first_i,
  input  logic [IDX_WIDTH-1:0]  beat_i,
  input  logic [DATA_WIDTH-1:0] logit_i,
  input  logic [DATA_WIDTH-1:0] max_i,
  input  logic [IDX_WIDTH-1:0]  idx_i,
`ifdef ARGMAX_MARGIN_EN
  input  logic [DATA_WIDTH-1:0] second_i,
  output logic [DATA_WIDTH-1:0] second_o,
`endif
  output logic [DATA_WIDTH-1:0] max_o,
  output logic [IDX_WIDTH-1:0]  idx_o
);

  logic gt_max;

  // Strict compare: an equal logit never displaces the earlier index.
  assign gt_max = $signed(logit_i) > $signed(max_i);

  always_comb begin
    max_o = max_i;
    idx_o = idx_i;
    if (first_i) begin
      max_o = logit_i;
      idx_o = '0;
    end else if (gt_max) begin
      max_o = logit_i;
      idx_o = beat_i;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic gt_second;

  assign gt_second = $signed(logit_i) > $signed(second_i);

  // The runner-up is the second element of the top-2 multiset, so a logit
  // equal to the max (but not above it) becomes the runner-up -> margin 0.
  always_comb begin
    second_o = second_i;
    if (first_i) begin
      second_o = MOST_NEG;
    end else if (gt_max) begin
      second_o = max_i;
    end else if (gt_second) begin
      second_o = logit_i;
    end
  end
`endif

endmodule

// File: rtl/mnist_argmax_unit.sv
// rtl/mnist_argmax_unit.sv - streaming argmax over NUM_CLASSES logits with one-deep output buffer
//
// Purpose: accumulates one logit per result_valid beat, and after the final
// beat of a frame presents the winning class/value (and margin) until the
// consumer accepts it. A frame completing while an earlier prediction is
// still pending is dropped and flagged in the sticky overflow bit.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   result        - signed logit input, result_valid qualifies it
//   frame_clr     - synchronous abort of a partial frame
//   pred_ready    - consumer accepts the prediction
//   pred_valid    - prediction available
//   pred_class    - winning index
//   pred_max      - winning logit
//   pred_margin   - winning logit minus runner-up (0 without ARGMAX_MARGIN_EN)
//   busy          - frame partially received
//   overflow      - sticky, a completed frame was dropped
//   frame_count   - completed frames, wrapping 16-bit
// Configuration macro: ARGMAX_MARGIN_EN (runner-up tracking and margin output)
module mnist_argmax_unit
  import mnist_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  result_valid,
  input  logic                  frame_clr,
  input  logic                  pred_ready,
  output logic                  pred_valid,
  output logic [IDX_WIDTH-1:0]  pred_class,
  output logic [DATA_WIDTH-1:0] pred_max,
  output logic [DATA_WIDTH-1:0] pred_margin,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           frame_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_BEAT = IDX_WIDTH'(NUM_CLASSES - 1);

  beat_state_e beat_state_q, beat_state_d;
  out_state_e  out_state_q, out_state_d;

  logic [IDX_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
  logic [DATA_WIDTH-1:0] fold_max;
  logic [IDX_WIDTH-1:0]  fold_idx;

  logic [IDX_WIDTH-1:0]  pred_class_q, pred_class_d;
  logic [DATA_WIDTH-1:0] pred_max_q, pred_max_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic first_beat, beat_en, final_beat, accept, load;

  // frame_clr wins over a simultaneous beat, so that beat never counts.
  assign first_beat = (beat_cnt_q == '0);
  assign beat_en    = result_valid && !frame_clr;
  assign final_beat = beat_en && (beat_cnt_q == LAST_BEAT);
  assign accept     = (out_state_q == OUT_FULL) && pred_ready;
  // A completing frame is loaded if the buffer is empty or is being drained
  // in this very cycle; otherwise it is dropped.
  assign load       = final_beat && ((out_state_q == OUT_EMPTY) || accept);

`ifdef ARGMAX_MARGIN_EN
  logic [DATA_WIDTH-1:0] run_second_q, run_second_d;
  logic [DATA_WIDTH-1:0] fold_second;
  logic [DATA_WIDTH-1:0] pred_margin_q, pred_margin_d;
  logic [DATA_WIDTH:0]   margin_wide;
  logic [DATA_WIDTH-1:0] margin_sat;

  // One extra bit so max - runner-up cannot wrap; the result is never
  // negative, so any set bit at or above the sign position means saturate.
  assign margin_wide = {fold_max[DATA_WIDTH-1], fold_max}
                     - {fold_second[DATA_WIDTH-1], fold_second};
  assign margin_sat  = (margin_wide[DATA_WIDTH] || margin_wide[DATA_WIDTH-1])
                     ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                     : margin_wide[DATA_WIDTH-1:0];
`endif

  argmax_cmp_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_cmp (
    .first_i (first_beat),
    .beat_i  (beat_cnt_q),
    .logit_i (result),
    .max_i   (run_max_q),
    .idx_i   (run_idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_i(run_second_q),
    .second_o(fold_second),
`endif
    .max_o   (fold_max),
    .idx_o   (fold_idx)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_state_q <= BEAT_IDLE;
      out_state_q  <= OUT_EMPTY;
    end else begin
      beat_state_q <= beat_state_d;
      out_state_q  <= out_state_d;
    end
  end

  // FSM next state
  always_comb begin
    beat_state_d = beat_state_q;
    case (beat_state_q)
      BEAT_IDLE:  if (beat_en && !final_beat) beat_state_d = BEAT_ACCUM;
      BEAT_ACCUM: if (frame_clr || final_beat) beat_state_d = BEAT_IDLE;
      default:    beat_state_d = BEAT_IDLE;
    endcase

    out_state_d = out_state_q;
    case (out_state_q)
      OUT_EMPTY: if (load) out_state_d = OUT_FULL;
      OUT_FULL:  if (accept && !load) out_state_d = OUT_EMPTY;
      default:   out_state_d = OUT_EMPTY;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (beat_state_q == BEAT_ACCUM);
    pred_valid = (out_state_q == OUT_FULL);
  end

  // Working and output register next state
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    pred_class_d  = pred_class_q;
    pred_max_d    = pred_max_q;
    overflow_d    = overflow_q || (final_beat && !load);
    frame_count_d = frame_count_q + 16'(final_beat);
`ifdef ARGMAX_MARGIN_EN
    run_second_d  = run_second_q;
    pred_margin_d = pred_margin_q;
`endif

    if (frame_clr) begin
      beat_cnt_d = '0;
      run_max_d  = '0;
      run_idx_d  = '0;
`ifdef ARGMAX_MARGIN_EN
      run_second_d = '0;
`endif
    end else if (result_valid) begin
      beat_cnt_d = final_beat ? '0 : beat_cnt_q + IDX_WIDTH'(1);
      run_max_d  = fold_max;
      run_idx_d  = fold_idx;
`ifdef ARGMAX_MARGIN_EN
      run_second_d = fold_second;
`endif
    end

    if (load) begin
      pred_class_d = fold_idx;
      pred_max_d   = fold_max;
`ifdef ARGMAX_MARGIN_EN
      pred_margin_d = margin_sat;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q    <= '0;
      run_max_q     <= '0;
      run_idx_q     <= '0;
      pred_class_q  <= '0;
      pred_max_q    <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      run_max_q     <= run_max_d;
      run_idx_q     <= run_idx_d;
      pred_class_q  <= pred_class_d;
      pred_max_q    <= pred_max_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

`ifdef ARGMAX_MARGIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_second_q  <= '0;
      pred_margin_q <= '0;
    end else begin
      run_second_q  <= run_second_d;
      pred_margin_q <= pred_margin_d;
    end
  end

  assign pred_margin = pred_margin_q;
`else
  assign pred_margin = '0;
`endif

  assign pred_class  = pred_class_q;
  assign pred_max    = pred_max_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_mnist_argmax_unit.sv
// tb/tb_mnist_argmax_unit.sv - scoreboard bench for mnist_argmax_unit
module tb_mnist_argmax_unit;

  localparam int NC = 10;
  localparam int DW = 32;
  localparam int IW = 4;
`ifdef ARGMAX_MARGIN_EN
  localparam bit MARGIN_EN = 1'b1;
`else
  localparam bit MARGIN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] result = '0;
  logic          result_valid = 1'b0;
  logic          frame_clr = 1'b0;
  logic          pred_ready = 1'b0;
  logic          pred_valid;
  logic [IW-1:0] pred_class;
  logic [DW-1:0] pred_max;
  logic [DW-1:0] pred_margin;
  logic          busy;
  logic          overflow;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  mnist_argmax_unit #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .result      (result),
    .result_valid(result_valid),
    .frame_clr   (frame_clr),
    .pred_ready  (pred_ready),
    .pred_valid  (pred_valid),
    .pred_class  (pred_class),
    .pred_max    (pred_max),
    .pred_margin (pred_margin),
    .busy        (busy),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [IW-1:0] cls;
    logic [DW-1:0] mx;
    logic [DW-1:0] mg;
  } exp_t;

  exp_t        exp_q[$];
  int          beats[$];
  bit          m_pending = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
  int          total = 0;
  int          bad = 0;
  int          fr[NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: argmax with lowest index on ties; margin = top value minus
  // the second entry of the descending sort, clipped to the positive max.
  function automatic exp_t ref_result(input int v[$]);
    exp_t   e;
    int     srt[$];
    int     best;
    longint d;
    best = 0;
    for (int i = 1; i < v.size(); i++)
      if (v[i] > v[best]) best = i;
    srt = v;
    srt.rsort();
    d = longint'(srt[0]) - longint'(srt[1]);
    if (d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
    e.cls = IW'(best);
    e.mx  = v[best];
    e.mg  = MARGIN_EN ? d[31:0] : 32'd0;
    return e;
  endfunction

  // Model of frames, output buffer, overflow and frame counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      exp_q.delete();
      m_pending = 1'b0;
      m_ovf = 1'b0;
      m_cnt = '0;
    end else begin
      bit acc, ld;
      acc = m_pending && pred_ready;
      ld = 1'b0;
      if (frame_clr) begin
        beats.delete();
      end else if (result_valid) begin
        beats.push_back(int'(result));
        if (beats.size() == NC) begin
          m_cnt = m_cnt + 16'd1;
          if (m_pending && !acc) m_ovf = 1'b1;
          else begin
            exp_q.push_back(ref_result(beats));
            ld = 1'b1;
          end
          beats.delete();
        end
      end
      if (ld) m_pending = 1'b1;
      else if (acc) m_pending = 1'b0;
    end
  end

  // Monitor: compares status every cycle and pops on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pred_valid", 64'(pred_valid), 64'(m_pending));
      chk("busy", 64'(busy), 64'(beats.size() != 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("frame_count", 64'(frame_count), 64'(m_cnt));
      if (pred_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pred actual=1 required=0 at %0t", $time);
        end else begin
          chk("pred_class", 64'(pred_class), 64'(exp_q[0].cls));
          chk("pred_max", 64'(pred_max), 64'(exp_q[0].mx));
          chk("pred_margin", 64'(pred_margin), 64'(exp_q[0].mg));
          if (pred_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v, input int d, input bit clr, input bit rdy);
    @(posedge clk);
    #1;
    result_valid = v;
    result = d;
    frame_clr = clr;
    pred_ready = rdy;
  endtask

  task automatic send_frame(input bit rdy);
    for (int i = 0; i < NC; i++) cyc(1'b1, fr[i], 1'b0, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, rdy);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_pred_valid", 64'(pred_valid), 64'd0);
    chk("rst_pred_class", 64'(pred_class), 64'd0);
    chk("rst_pred_max", 64'(pred_max), 64'd0);
    chk("rst_pred_margin", 64'(pred_margin), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    result_valid = 1'b0;
    frame_clr = 1'b0;
    pred_ready = 1'b0;
    #2;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int v;
    #3;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Tie between beats 2 and 4: lowest index wins, margin 0.
    fr = '{5, -3, 9, 2, 9, 0, -1, 1, 4, 8};
    send_frame(1'b0);
    idle(1, 1'b0);
    chk("d034_class", 64'(pred_class), 64'd2);
    chk("d034_max", 64'(pred_max), 64'd9);
    chk("d034_margin", 64'(pred_margin), 64'd0);
    idle(2, 1'b1);

    // All negative, single winner at index 7.
    for (int i = 0; i < NC; i++) fr[i] = -100;
    fr[7] = -50;
    send_frame(1'b0);
    idle(1, 1'b0);
    chk("d035_class", 64'(pred_class), 64'd7);
    chk("d035_max", 64'(pred_max), 64'(32'hFFFF_FFCE));
    chk("d035_margin", 64'(pred_margin), MARGIN_EN ? 64'd50 : 64'd0);
    idle(2, 1'b1);

    // Two frames back-to-back, consumer stalled: second frame dropped.
    for (int i = 0; i < NC; i++) fr[i] = i;
    send_frame(1'b0);
    for (int i = 0; i < NC; i++) fr[i] = NC - i;
    send_frame(1'b0);
    idle(2, 1'b0);
    chk("d036_class", 64'(pred_class), 64'd9);
    chk("d036_overflow", 64'(overflow), 64'd1);
    idle(2, 1'b1);

    // Abort after beat 4 (with a colliding beat), then a full frame.
    for (int i = 0; i < 5; i++) cyc(1'b1, 100 + i, 1'b0, 1'b0);
    cyc(1'b1, 500, 1'b1, 1'b0);
    for (int i = 0; i < NC; i++) fr[i] = i;
    send_frame(1'b0);
    idle(1, 1'b0);
    chk("d037_class", 64'(pred_class), 64'd9);
    chk("d037_max", 64'(pred_max), 64'd9);
    idle(2, 1'b1);

    // Reset pulsed after beat 6, then a fresh frame.
    for (int i = 0; i < 7; i++) cyc(1'b1, 1000, 1'b0, 1'b0);
    pulse_reset();
    fr = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(1'b0);
    idle(1, 1'b0);
    chk("d038_class", 64'(pred_class), 64'd5);
    chk("d038_frame_count", 64'(frame_count), 64'd1);
    idle(2, 1'b1);

    // Extreme spread: margin saturates.
    for (int i = 0; i < NC; i++) fr[i] = int'(32'h8000_0000);
    fr[0] = int'(32'h7FFF_FFFF);
    send_frame(1'b0);
    idle(1, 1'b0);
    chk("d039_margin", 64'(pred_margin), MARGIN_EN ? 64'h7FFF_FFFF : 64'd0);

    // Next frame completes in the handshake cycle: loaded, no overflow.
    for (int i = 0; i < NC; i++) fr[i] = i;
    for (int i = 0; i < NC; i++) cyc(1'b1, fr[i], 1'b0, i == NC - 1);
    idle(1, 1'b0);
    chk("d024_class", 64'(pred_class), 64'd9);
    chk("d024_overflow", 64'(overflow), 64'd0);
    idle(2, 1'b1);

    // Randomised traffic with gaps, aborts, stalls and frequent ties.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 15)) - 8;
      else v = int'($urandom);
      cyc($urandom_range(0, 9) < 8, v, $urandom_range(0, 39) == 0,
          $urandom_range(0, 2) != 0);
    end
    idle(5, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
